// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the IF/ID register.
// Owns the PC, issues single-outstanding fetches on a req/gnt/rvalid bus,
// holds one fetched instruction for IF/ID and redirects on jumps,
// discarding any in-flight response that belongs to the old stream.
module ifu_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] INST_NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] INST_STEP = 32'd4;

  // REQ: issuing; WAIT: response pending for r_req_addr; DRAIN: stale response pending
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_addr;
  logic            r_valid;

  logic            w_req;
  logic            w_grant;
  logic            w_consume;
  logic [XLEN-1:0] w_jump_tgt;

  // Never request while a held bundle is stuck, so the slot is empty on response
  assign w_req      = !rst && (r_state == S_REQ) && (!r_valid || !hold_i);
  assign w_grant    = w_req && ibus_gnt_i;
  assign w_consume  = r_valid && !hold_i;
  assign w_jump_tgt = jump_addr_i & WORD_MASK;

  assign ibus_req_o   = w_req;
  assign ibus_addr_o  = r_pc;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
  assign inst_valid_o = r_valid;

  // Fetch FSM, PC and output slot; a jump overrides everything else on its edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_ADDR;
      r_req_addr  <= RESET_ADDR;
      r_inst      <= INST_NOP;
      r_inst_addr <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (w_consume) begin
        r_valid <= 1'b0;
        r_inst  <= INST_NOP;
      end

      if (jump_en_i) begin
        r_pc    <= w_jump_tgt;
        r_valid <= 1'b0;
        r_inst  <= INST_NOP;
        case (r_state)
          S_REQ:   r_state <= w_grant ? S_DRAIN : S_REQ;
          S_WAIT:  r_state <= ibus_rvalid_i ? S_REQ : S_DRAIN;
          S_DRAIN: r_state <= ibus_rvalid_i ? S_REQ : S_DRAIN;
          default: r_state <= S_REQ;
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            if (w_grant) begin
              r_req_addr <= r_pc;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (ibus_rvalid_i) begin
              r_inst      <= ibus_rdata_i;
              r_inst_addr <= r_req_addr;
              r_valid     <= 1'b1;
              r_pc        <= r_req_addr + INST_STEP;
              r_state     <= S_REQ;
            end
          end
          S_DRAIN: begin
            if (ibus_rvalid_i) begin
              r_state <= S_REQ;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small latency-programmable memory model.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;

  // memory model controls
  logic        gnt_en;
  logic [3:0]  m_lat;
  logic        m_pend;
  logic [3:0]  m_cnt;
  logic [31:0] m_addr;

  int n_cmp;
  int n_err;

  ifu_fetch #(
    .RESET_ADDR(32'h0000_0000),
    .INST_NOP  (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .hold_i       (hold),
    .ibus_req_o   (ibus_req),
    .ibus_addr_o  (ibus_addr),
    .ibus_gnt_i   (ibus_gnt),
    .ibus_rvalid_i(ibus_rvalid),
    .ibus_rdata_i (ibus_rdata),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // grant is combinational on request; response comes m_lat cycles after the one following gnt
  assign ibus_gnt    = ibus_req && gnt_en;
  assign ibus_rvalid = m_pend && (m_cnt == 4'd0);
  assign ibus_rdata  = ibus_rvalid ? mem_word(m_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_cnt  <= 4'd0;
      m_addr <= 32'd0;
    end else if (ibus_req && ibus_gnt) begin
      m_pend <= 1'b1;
      m_cnt  <= m_lat;
      m_addr <= ibus_addr;
    end else if (ibus_rvalid) begin
      m_pend <= 1'b0;
    end else if (m_pend) begin
      m_cnt <= m_cnt - 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    jump_en   = 1'b0;
    jump_addr = 32'd0;
    hold      = 1'b0;
    gnt_en    = 1'b1;
    m_lat     = 4'd0;

    // reset values
    #12;
    check("rst_req", 32'(ibus_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, NOP);
    check("rst_iaddr", inst_addr, 32'd0);
    check("rst_pc", ibus_addr, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;

    // zero-wait streaming: 0,4,8
    for (int k = 0; k < 3; k++) begin
      check("seq_req", 32'(ibus_req), 32'd1);
      check("seq_addr", ibus_addr, 32'(k * 4));
      tick();
      check("seq_wait_valid", 32'(inst_valid), 32'd0);
      check("seq_wait_req", 32'(ibus_req), 32'd0);
      tick();
      check("seq_valid", 32'(inst_valid), 32'd1);
      check("seq_inst", inst, mem_word(32'(k * 4)));
      check("seq_iaddr", inst_addr, 32'(k * 4));
    end

    // hold with bundle at 8 valid
    hold = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("hold_req", 32'(ibus_req), 32'd0);
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_inst", inst, mem_word(32'h8));
      check("hold_iaddr", inst_addr, 32'h8);
      tick();
    end
    hold = 1'b0;
    #1;
    check("unhold_req", 32'(ibus_req), 32'd1);
    check("unhold_addr", ibus_addr, 32'hC);
    tick();
    check("unhold_wait_valid", 32'(inst_valid), 32'd0);
    tick();
    check("unhold_inst", inst, mem_word(32'hC));
    check("unhold_iaddr", inst_addr, 32'hC);

    // jump in WAIT without rvalid; stale response 3 cycles later
    m_lat = 4'd3;
    check("j1_addr_pre", ibus_addr, 32'h10);
    tick();
    check("j1_wait_rvalid", 32'(ibus_rvalid), 32'd0);
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0103;
    tick();
    jump_en = 1'b0;
    m_lat   = 4'd0;
    check("j1_pc", ibus_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      check("j1_drain_req", 32'(ibus_req), 32'd0);
      check("j1_drain_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    check("j1_req", 32'(ibus_req), 32'd1);
    check("j1_req_addr", ibus_addr, 32'h100);
    check("j1_valid0", 32'(inst_valid), 32'd0);
    tick();
    check("j1_wait_valid", 32'(inst_valid), 32'd0);
    tick();
    check("j1_valid", 32'(inst_valid), 32'd1);
    check("j1_inst", inst, mem_word(32'h100));
    check("j1_iaddr", inst_addr, 32'h100);

    // jump coincident with rvalid in WAIT
    tick();
    check("j2_rvalid", 32'(ibus_rvalid), 32'd1);
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0040;
    tick();
    jump_en = 1'b0;
    #1;
    check("j2_valid", 32'(inst_valid), 32'd0);
    check("j2_inst", inst, NOP);
    check("j2_req", 32'(ibus_req), 32'd1);
    check("j2_addr", ibus_addr, 32'h40);
    tick();
    tick();
    check("j2_inst_new", inst, mem_word(32'h40));
    check("j2_iaddr_new", inst_addr, 32'h40);

    // jump under hold clears the held slot
    hold      = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0080;
    #1;
    check("jh_req_blocked", 32'(ibus_req), 32'd0);
    tick();
    jump_en = 1'b0;
    #1;
    check("jh_valid", 32'(inst_valid), 32'd0);
    check("jh_inst", inst, NOP);
    check("jh_req", 32'(ibus_req), 32'd1);
    check("jh_addr", ibus_addr, 32'h80);
    hold = 1'b0;
    tick();
    tick();
    check("jh_inst_new", inst, mem_word(32'h80));

    // jump in REQ with gnt, second jump during DRAIN
    m_lat     = 4'd2;
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0300;
    #1;
    check("j3_gnt", 32'(ibus_gnt), 32'd1);
    tick();
    jump_addr = 32'h0000_0200;
    check("j3_drain_req", 32'(ibus_req), 32'd0);
    check("j3_pc1", ibus_addr, 32'h300);
    tick();
    jump_en = 1'b0;
    m_lat   = 4'd0;
    check("j3_pc2", ibus_addr, 32'h200);
    check("j3_drain_req2", 32'(ibus_req), 32'd0);
    tick();
    check("j3_stale_rvalid", 32'(ibus_rvalid), 32'd1);
    check("j3_drain_req3", 32'(ibus_req), 32'd0);
    tick();
    check("j3_valid", 32'(inst_valid), 32'd0);
    check("j3_req", 32'(ibus_req), 32'd1);
    check("j3_addr", ibus_addr, 32'h200);
    tick();
    tick();
    check("j3_inst", inst, mem_word(32'h200));
    check("j3_iaddr", inst_addr, 32'h200);

    // PC wrap from 0xFFFF_FFFC; also no-gnt stall keeps pc
    gnt_en    = 1'b0;
    jump_en   = 1'b1;
    jump_addr = 32'hFFFF_FFFF;
    tick();
    jump_en = 1'b0;
    check("wrap_pc", ibus_addr, 32'hFFFF_FFFC);
    tick();
    check("stall_req", 32'(ibus_req), 32'd1);
    check("stall_pc", ibus_addr, 32'hFFFF_FFFC);
    gnt_en = 1'b1;
    tick();
    tick();
    check("wrap_inst", inst, mem_word(32'hFFFF_FFFC));
    check("wrap_iaddr", inst_addr, 32'hFFFF_FFFC);
    check("wrap_next", ibus_addr, 32'h0);

    // async reset mid-WAIT
    gnt_en    = 1'b0;
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0500;
    tick();
    jump_en = 1'b0;
    gnt_en  = 1'b1;
    m_lat   = 4'd3;
    #1;
    check("r2_addr", ibus_addr, 32'h500);
    tick();
    check("r2_wait_req", 32'(ibus_req), 32'd0);
    rst = 1'b1;
    #1;
    check("r2_req", 32'(ibus_req), 32'd0);
    check("r2_pc", ibus_addr, 32'd0);
    check("r2_valid", 32'(inst_valid), 32'd0);
    check("r2_inst", inst, NOP);
    check("r2_iaddr", inst_addr, 32'd0);
    m_lat = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("r2_restart_req", 32'(ibus_req), 32'd1);
    tick();
    tick();
    check("r2_restart_inst", inst, mem_word(32'h0));
    check("r2_restart_iaddr", inst_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
